// File: rtl/seq_hit_logger_pkg.sv
// Shared definitions for the detector-chain stages: default sizes and
// a saturating increment helper.
package seq_hit_logger_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

  // Increment val but never past the all-ones value of a width-bit counter (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: dout shows the head entry combinationally.
// Occupancy is tracked explicitly; full/empty come from it, not from pointers.
module sync_fifo_fwft
  import seq_hit_logger_pkg::*;
#(
  parameter int W     = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign do_push = push & (~full | pop) & ~clr;
  assign do_pop  = pop & ~empty & ~clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/seq_hit_logger.sv
// Timestamps rising edges of the sequence detector's match output and queues
// them for readout, with saturating hit/drop counters and a sticky overflow flag.
module seq_hit_logger
  import seq_hit_logger_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     hit_in,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [TS_W-1:0]          ev_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         hit_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     overflow
);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic             hit_d_q, hit_d_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic             overflow_q, overflow_d;

  logic             hit_event, pop, drop;
  logic             fifo_full, fifo_empty;
  logic [TS_W-1:0]  fifo_dout;

  assign hit_event = hit_in & ~hit_d_q;
  assign ev_valid  = ~fifo_empty;
  assign pop       = ev_valid & ev_ready;
  assign drop      = hit_event & fifo_full & ~pop;

  sync_fifo_fwft #(.W(TS_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .push  (hit_event),
    .pop   (pop),
    .din   (ts_q),
    .dout  (fifo_dout),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Storage is not reset, so mask the head while nothing is queued.
  assign ev_ts = ev_valid ? fifo_dout : '0;

  always_comb begin
    ts_d         = ts_q + TS_W'(1);
    hit_d_d      = hit_in;
    hit_count_d  = hit_count_q;
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;
    if (clr) begin
      ts_d         = '0;
      hit_count_d  = '0;
      drop_count_d = '0;
      overflow_d   = 1'b0;
    end else if (hit_event) begin
      hit_count_d = CNT_W'(sat_inc(32'(hit_count_q), CNT_W));
      if (drop) begin
        drop_count_d = CNT_W'(sat_inc(32'(drop_count_q), CNT_W));
        overflow_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q         <= '0;
      hit_d_q      <= 1'b0;
      hit_count_q  <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      ts_q         <= ts_d;
      hit_d_q      <= hit_d_d;
      hit_count_q  <= hit_count_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign drop_count = drop_count_q;
  assign overflow   = overflow_q;

endmodule
